// File: rtl/wn_rr_scheduler.sv
// wn_rr_scheduler: round-robin issue of NUM_REQ requesters onto one pipelined wn datapath with tagged result return
module wn_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4,
  parameter int W_WIDTH = 19
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [8*NUM_REQ-1:0]       req_x_i,
  input  logic [8*NUM_REQ-1:0]       req_y_i,
  input  logic [8*NUM_REQ-1:0]       req_z_i,
  output logic [NUM_REQ-1:0]         res_valid_o,
  input  logic [NUM_REQ-1:0]         res_ready_i,
  output logic [W_WIDTH*NUM_REQ-1:0] res_w_o,
  output logic                       dp_en_o,
  output logic [7:0]                 dp_x_o,
  output logic [7:0]                 dp_y_o,
  output logic [7:0]                 dp_z_o,
  input  logic [W_WIDTH-1:0]         dp_w_i,
  input  logic                       dp_valid_i,
  output logic [NUM_REQ-1:0]         busy_o,
  output logic                       err_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic {FLUSH, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] ptr, gnt, k, dp_idx;
  logic found, run, fire;
  logic tag_v [LATENCY];
  logic [IW-1:0] tag_i [LATENCY];
  assign run = state == RUN;
  assign fire = run && found;
  assign req_ready_o = fire ? NUM_REQ'(1) << gnt : '0;
  always_comb begin
    state_nx = (run || cnt == '0) ? RUN : FLUSH;
    cnt_nx = (run || cnt == '0) ? cnt : cnt - 1'b1;
  end
  always_comb begin
    gnt = ptr;
    k = '0;
    found = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IW'((int'(ptr) + i) % NUM_REQ);
      if (req_valid_i[k] && !busy_o[k]) begin
        gnt = k;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= FLUSH;
      cnt <= CW'(LATENCY - 1);
      ptr <= IW'(NUM_REQ - 1);
      dp_idx <= '0;
      dp_en_o <= 1'b0;
      dp_x_o <= '0;
      dp_y_o <= '0;
      dp_z_o <= '0;
      busy_o <= '0;
      res_valid_o <= '0;
      res_w_o <= '0;
      err_o <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_v[i] <= 1'b0;
        tag_i[i] <= '0;
      end
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      dp_en_o <= fire;
      if (fire) begin
        ptr <= gnt;
        dp_idx <= gnt;
        dp_x_o <= req_x_i[8*gnt +: 8];
        dp_y_o <= req_y_i[8*gnt +: 8];
        dp_z_o <= req_z_i[8*gnt +: 8];
      end
      tag_v[0] <= dp_en_o;
      tag_i[0] <= dp_idx;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        if (res_valid_o[r] && res_ready_i[r]) begin
          res_valid_o[r] <= 1'b0;
          busy_o[r] <= 1'b0;
        end
        if (fire && gnt == IW'(r))
          busy_o[r] <= 1'b1;
        if (run && tag_v[LATENCY-1] && tag_i[LATENCY-1] == IW'(r)) begin
          if (dp_valid_i) begin
            res_valid_o[r] <= 1'b1;
            res_w_o[W_WIDTH*r +: W_WIDTH] <= dp_w_i;
          end else
            busy_o[r] <= 1'b0;
        end
      end
      if (run && dp_valid_i != tag_v[LATENCY-1])
        err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wn_rr_scheduler.sv
// tb_wn_rr_scheduler: randomized self-checking bench for wn_rr_scheduler against a rule-level model
module tb_wn_rr_scheduler;
  localparam int N = 4;
  localparam int LAT = 4;
  localparam int WW = 19;
  typedef struct {int r; int due; logic [WW-1:0] w;} op_t;
  logic clk_i = 1'b0;
  logic rst_ni;
  logic [N-1:0] req_valid_i, req_ready_o, res_valid_o, res_ready_i, busy_o;
  logic [8*N-1:0] req_x_i, req_y_i, req_z_i;
  logic [WW*N-1:0] res_w_o;
  logic dp_en_o, dp_valid_i, err_o;
  logic [7:0] dp_x_o, dp_y_o, dp_z_o;
  logic [WW-1:0] dp_w_i;
  logic force_v = 1'b0;
  logic kill_v = 1'b0;
  logic [LAT-1:0] pv = '0;
  logic [WW-1:0] pw [LAT];
  int checks = 0;
  int failures = 0;
  int flush_left, mptr, ecount, last_g, acc_edge, en_cnt;
  logic [N-1:0] mbusy, mres_v, obs_rdy, prev_rdy;
  logic [WW-1:0] mres_w [N];
  logic merr;
  op_t pend[$];
  int lat, n0, n3, due, n, en0;
  wn_rr_scheduler #(.NUM_REQ(N), .LATENCY(LAT), .W_WIDTH(WW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_x_i(req_x_i), .req_y_i(req_y_i), .req_z_i(req_z_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_w_o(res_w_o),
    .dp_en_o(dp_en_o), .dp_x_o(dp_x_o), .dp_y_o(dp_y_o), .dp_z_o(dp_z_o),
    .dp_w_i(dp_w_i), .dp_valid_i(dp_valid_i),
    .busy_o(busy_o), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [WW-1:0] wn_ref(logic [7:0] x, logic [7:0] y, logic [7:0] z);
    int xs, ys, zu;
    xs = int'($signed(x));
    ys = int'($signed(y));
    zu = int'(z);
    return WW'(2*xs*ys + ys*zu + 128*xs + 256*ys + 64*zu);
  endfunction
  always @(posedge clk_i) begin
    pv <= {pv[LAT-2:0], dp_en_o};
    pw[0] <= wn_ref(dp_x_o, dp_y_o, dp_z_o);
    for (int i = 1; i < LAT; i++)
      pw[i] <= pw[i-1];
  end
  assign dp_valid_i = (pv[LAT-1] | force_v) & ~kill_v;
  assign dp_w_i = pw[LAT-1];
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rand_ops();
    req_x_i = $urandom();
    req_y_i = $urandom();
    req_z_i = $urandom();
  endtask
  task automatic step();
    int g;
    logic dv, run_pre;
    logic [7:0] ax, ay, az;
    logic [N-1:0] exp_r, pops;
    op_t o;
    #1;
    g = -1;
    run_pre = flush_left == 0;
    if (run_pre)
      for (int i = N; i >= 1; i--)
        if (req_valid_i[(mptr + i) % N] && !mbusy[(mptr + i) % N])
          g = (mptr + i) % N;
    exp_r = '0;
    if (g >= 0)
      exp_r[g] = 1'b1;
    obs_rdy = req_ready_o;
    chk("req_ready", req_ready_o, exp_r);
    dv = dp_valid_i;
    pops = mres_v & res_ready_i;
    ax = '0;
    ay = '0;
    az = '0;
    if (g >= 0) begin
      ax = req_x_i[8*g +: 8];
      ay = req_y_i[8*g +: 8];
      az = req_z_i[8*g +: 8];
    end
    @(posedge clk_i);
    ecount++;
    if (flush_left > 0)
      flush_left--;
    mres_v &= ~pops;
    mbusy &= ~pops;
    last_g = g;
    if (g >= 0) begin
      mbusy[g] = 1'b1;
      mptr = g;
      acc_edge = ecount;
      o.r = g;
      o.due = ecount + LAT + 1;
      o.w = wn_ref(ax, ay, az);
      pend.push_back(o);
    end
    if (pend.size() > 0 && pend[0].due == ecount) begin
      o = pend.pop_front();
      if (dv) begin
        mres_v[o.r] = 1'b1;
        mres_w[o.r] = o.w;
      end else begin
        mbusy[o.r] = 1'b0;
        merr = 1'b1;
      end
    end else if (dv && run_pre)
      merr = 1'b1;
    @(negedge clk_i);
    en_cnt += int'(dp_en_o);
    chk("dp_en", dp_en_o, g >= 0);
    if (g >= 0)
      chk("dp_ops", {dp_x_o, dp_y_o, dp_z_o}, {ax, ay, az});
    chk("busy", busy_o, mbusy);
    chk("res_valid", res_valid_o, mres_v);
    for (int r = 0; r < N; r++)
      if (mres_v[r])
        chk("res_w", res_w_o[WW*r +: WW], mres_w[r]);
    chk("err", err_o, merr);
  endtask
  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_w", res_w_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_dp_en", dp_en_o, 0);
    chk("rst_dp_ops", {dp_x_o, dp_y_o, dp_z_o}, 0);
    chk("rst_err", err_o, 0);
    flush_left = LAT;
    mptr = N - 1;
    mbusy = '0;
    mres_v = '0;
    merr = 1'b0;
    pend.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask
  task automatic wait_acc(int r, string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (last_g != r && k < 20);
    chk(tag, last_g, r);
  endtask
  task automatic drop_at_due();
    int k = 0;
    due = acc_edge + LAT + 1;
    while (ecount < due - 1 && k < 20) begin
      step();
      k++;
    end
    kill_v = 1'b1;
    step();
    kill_v = 1'b0;
  endtask
  task automatic drain();
    req_valid_i = '0;
    res_ready_i = '1;
    repeat (10) step();
  endtask
  initial begin
    rst_ni = 1'b1;
    ecount = 0;
    en_cnt = 0;
    req_valid_i = '1;
    res_ready_i = '0;
    rand_ops();
    #2;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t1_grant", obs_rdy, c < 4 ? 4'b0 : (c < 8 ? 4'(1 << (c - 4)) : 4'b0));
    end
    chk("t1_dp_en_count", en_cnt, 4);
    drain();
    req_valid_i = 4'b0100;
    res_ready_i = '0;
    req_x_i[23:16] = 8'h40;
    req_y_i[23:16] = 8'h40;
    req_z_i[23:16] = 8'h80;
    wait_acc(2, "t2_acc");
    req_valid_i = '0;
    lat = 0;
    while (lat < 10 && !res_valid_o[2]) begin
      step();
      lat++;
    end
    chk("t2_latency", lat, 5);
    chk("t2_w", res_w_o[56:38], 19'd49152);
    res_ready_i = 4'b0100;
    step();
    req_valid_i = 4'b0010;
    res_ready_i = '0;
    req_x_i[15:8] = 8'h80;
    req_y_i[15:8] = 8'h80;
    req_z_i[15:8] = 8'h00;
    wait_acc(1, "t3_acc");
    repeat (5) step();
    chk("t3_valid", res_valid_o[1], 1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t3_no_regrant", obs_rdy[1], 0);
      chk("t3_stable", res_w_o[37:19], wn_ref(8'h80, 8'h80, 8'h00));
    end
    res_ready_i = 4'b0010;
    step();
    res_ready_i = '0;
    step();
    chk("t3_regrant", obs_rdy, 4'b0010);
    drain();
    req_valid_i = 4'b1001;
    res_ready_i = '1;
    prev_rdy = '0;
    n0 = 0;
    n3 = 0;
    for (int c = 0; c < 40; c++) begin
      rand_ops();
      step();
      if (obs_rdy != '0) begin
        chk("t4_alternate", obs_rdy != prev_rdy, 1);
        prev_rdy = obs_rdy;
        n0 += int'(obs_rdy == 4'b0001);
        n3 += int'(obs_rdy == 4'b1000);
      end
    end
    chk("t4_req0_served", n0 >= 4, 1);
    chk("t4_req3_served", n3 >= 4, 1);
    drain();
    force_v = 1'b1;
    step();
    force_v = 1'b0;
    chk("t5_spurious_err", err_o, 1);
    chk("t5_no_result", res_valid_o, 0);
    repeat (3) step();
    chk("t5_sticky", err_o, 1);
    req_valid_i = 4'b0001;
    wait_acc(0, "t5_acc");
    req_valid_i = '0;
    drop_at_due();
    chk("t5_drop_busy", busy_o[0], 0);
    chk("t5_drop_res", res_valid_o[0], 0);
    chk("t5_drop_err", err_o, 1);
    req_valid_i = '1;
    res_ready_i = '0;
    rand_ops();
    en0 = en_cnt;
    repeat (3) step();
    chk("t6_issued", en_cnt - en0, 3);
    do_reset();
    req_valid_i = '0;
    res_ready_i = '1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t6_no_res", res_valid_o, 0);
      chk("t6_no_err", err_o, 0);
    end
    for (int c = 0; c < 400; c++) begin
      req_valid_i = 4'($urandom());
      res_ready_i = 4'($urandom());
      rand_ops();
      step();
    end
    drain();
    do_reset();
    req_valid_i = 4'b0001;
    wait_acc(0, "t8_acc");
    req_valid_i = '0;
    drop_at_due();
    chk("t8_drop_err", err_o, 1);
    chk("t8_drop_busy", busy_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
